// File: rtl/e42_ser.sv
// Serializing 4-to-2 encoder: emits the index of each set bit of a captured
// word, highest first, over a valid/ready stream (feeds a 2x4 decoder).
//
// state | meaning
// IDLE  | waiting for a word; in_ready follows e
// BUSY  | emitting codes for the bits remaining in pend_q
module e42_ser (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic [3:0] d,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] a,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       last,
    output logic [2:0] count,
    output logic       empty
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [2:0] pop4(input logic [3:0] w);
        return {2'b00, w[0]} + {2'b00, w[1]} + {2'b00, w[2]} + {2'b00, w[3]};
    endfunction

    function automatic logic [1:0] hi_idx(input logic [3:0] w);
        if (w[3])      return 2'd3;
        else if (w[2]) return 2'd2;
        else if (w[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] pend_q, pend_d;
    logic [1:0] a_q, a_d;
    logic       out_valid_q, out_valid_d;
    logic       last_q, last_d;
    logic [2:0] count_q, count_d;
    logic       empty_q, empty_d;

    logic       accept;
    logic [3:0] pend_rem;

    assign in_ready = e & (state_q == IDLE) & ~rst;
    assign accept   = in_valid & in_ready;
    // Word left once the code currently presented is consumed
    assign pend_rem = pend_q & ~(4'b0001 << a_q);

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        a_d         = a_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        count_d     = count_q;
        empty_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (d == 4'b0000) begin
                        empty_d = 1'b1;
                        count_d = 3'd0;
                    end else begin
                        pend_d      = d;
                        count_d     = pop4(d);
                        a_d         = hi_idx(d);
                        last_d      = (pop4(d) == 3'd1);
                        out_valid_d = 1'b1;
                        state_d     = BUSY;
                    end
                end
            end
            BUSY: begin
                if (out_valid_q && out_ready) begin
                    pend_d = pend_rem;
                    if (last_q) begin
                        out_valid_d = 1'b0;
                        last_d      = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        a_d    = hi_idx(pend_rem);
                        last_d = (pop4(pend_rem) == 3'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= 4'b0000;
            a_q         <= 2'b00;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            count_q     <= 3'd0;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            a_q         <= a_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
        end
    end

    assign a         = a_q;
    assign out_valid = out_valid_q;
    assign last      = last_q;
    assign count     = count_q;
    assign empty     = empty_q;

endmodule

// File: tb/tb_e42_ser.sv
// Scoreboard bench for e42_ser: stimulus queues expected codes, a negedge
// monitor pops them on each handshake and rebuilds each word via a 2x4 decode.
module tb_e42_ser;

    logic       clk;
    logic       rst;
    logic       e;
    logic [3:0] d;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] a;
    logic       out_valid;
    logic       out_ready;
    logic       last;
    logic [2:0] count;
    logic       empty;

    e42_ser dut (
        .clk      (clk),
        .rst      (rst),
        .e        (e),
        .d        (d),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .last     (last),
        .count    (count),
        .empty    (empty)
    );

    typedef struct packed {
        logic [1:0] a;
        logic       last;
        logic [2:0] count;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] word_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    logic [3:0] acc;
    logic       stall_prev;
    logic [1:0] s_a;
    logic       s_last;
    logic [2:0] s_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int ca, input int cl, input int cc);
        exp_t x;
        x.a     = ca[1:0];
        x.last  = cl[0];
        x.count = cc[2:0];
        exp_q.push_back(x);
    endtask

    task automatic push_model(input logic [3:0] w);
        int cnt;
        int n;
        cnt = 0;
        for (int k = 0; k < 4; k++) cnt += int'(w[k]);
        n = 0;
        for (int k = 3; k >= 0; k--) begin
            if (w[k]) begin
                n++;
                push(k, (n == cnt) ? 1 : 0, cnt);
            end
        end
        if (w != 4'b0000) word_q.push_back(w);
    endtask

    // Present a word, wait (bounded) for in_ready, return just after the accept edge
    task automatic send(input logic [3:0] w);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        d        = w;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_in_ready_timeout", 0, 1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 0, 1);
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (rst) begin
            acc        = 4'b0000;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_a", int'(a), int'(s_a));
                check("stall_last", int'(last), int'(s_last));
                check("stall_count", int'(count), int'(s_count));
                check("stall_out_valid", int'(out_valid), 1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_code", int'(a), -1);
                end else begin
                    x = exp_q.pop_front();
                    check("code_a", int'(a), int'(x.a));
                    check("code_last", int'(last), int'(x.last));
                    check("code_count", int'(count), int'(x.count));
                    acc = acc | (4'b0001 << a);
                    if (last) begin
                        if (word_q.size() > 0) check("round_trip", int'(acc), int'(word_q.pop_front()));
                        acc = 4'b0000;
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            s_a        = a;
            s_last     = last;
            s_count    = count;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst       = 1'b1;
        e         = 1'b1;
        in_valid  = 1'b1;
        d         = 4'b1111;
        out_ready = 1'b1;

        // Reset with a valid word presented: nothing may be captured
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_in_ready", int'(in_ready), 0);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_a", int'(a), 0);
            check("rst_count", int'(count), 0);
            check("rst_empty", int'(empty), 0);
        end
        @(posedge clk);
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", int'(out_valid), 0);
        check("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #2;

        // Full word 1011 without stalls: 3,1,0 with last on the final code
        push(3, 0, 3);
        push(1, 0, 3);
        push(0, 1, 3);
        word_q.push_back(4'b1011);
        send(4'b1011);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid && last) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("full_last_timeout", 0, 1);
        check("full_in_ready_busy", int'(in_ready), 0);
        @(negedge clk);
        check("full_in_ready_back", int'(in_ready), 1);
        check("full_out_valid_low", int'(out_valid), 0);
        wait_idle();

        // Stall on 0110: first code held for 3 cycles, then 1 with last
        out_ready = 1'b0;
        push(2, 0, 2);
        push(1, 1, 2);
        word_q.push_back(4'b0110);
        send(4'b0110);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold_a", int'(a), 2);
            check("stall_hold_valid", int'(out_valid), 1);
            check("stall_hold_last", int'(last), 0);
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        wait_idle();

        // Back-to-back zero words: empty pulses on two consecutive cycles
        in_valid = 1'b1;
        d        = 4'b0000;
        @(negedge clk);
        check("zero_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #2;
        @(negedge clk);
        check("zero_empty_1", int'(empty), 1);
        check("zero_out_valid", int'(out_valid), 0);
        check("zero_count", int'(count), 0);
        check("zero_in_ready_held", int'(in_ready), 1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        @(negedge clk);
        check("zero_empty_2", int'(empty), 1);
        @(posedge clk);
        #2;
        @(negedge clk);
        check("zero_empty_clear", int'(empty), 0);
        @(posedge clk);
        #2;

        // Enable low in IDLE: word is dropped
        e        = 1'b0;
        in_valid = 1'b1;
        d        = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("en_off_in_ready", int'(in_ready), 0);
            check("en_off_out_valid", int'(out_valid), 0);
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        e        = 1'b1;
        @(negedge clk);
        check("en_off_no_output", int'(out_valid), 0);
        @(posedge clk);
        #2;

        // Enable dropped after first code: word still drains fully
        push(3, 0, 4);
        push(2, 0, 4);
        push(1, 0, 4);
        push(0, 1, 4);
        word_q.push_back(4'b1111);
        send(4'b1111);
        @(posedge clk);
        #2;
        e = 1'b0;
        wait_idle();
        e = 1'b1;

        // Reset after the second code: remaining codes discarded
        push(3, 0, 4);
        push(2, 0, 4);
        push(1, 0, 4);
        push(0, 1, 4);
        word_q.push_back(4'b1111);
        send(4'b1111);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        word_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_out_valid", int'(out_valid), 0);
            @(posedge clk);
            #2;
        end

        // All 16 words through the encoder and the bench's 2x4 decode
        for (int w = 0; w < 16; w++) begin
            logic [3:0] wv;
            int         pc;
            wv = w[3:0];
            pc = 0;
            for (int k = 0; k < 4; k++) pc += int'(wv[k]);
            push_model(wv);
            send(wv);
            @(negedge clk);
            check("sweep_count", int'(count), pc);
            check("sweep_empty", int'(empty), (wv == 4'b0000) ? 1 : 0);
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/e42_ser.md
# e42_ser

Serializing 4-to-2 encoder: the inverse of the 2-to-4 decoder. It accepts a 4-bit multi-hot word and emits one 2-bit code per set bit, highest bit first, over a valid/ready stream. Codes are presented in the form the 2x4 decoder consumes, so cascading `e42_ser` into `d24` reproduces each set bit as a one-hot output. Used wherever several request lines must be turned into a sequence of indices.

## Interface
- No parameters. Widths are fixed: 4-bit word, 2-bit code.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `e` input 1: enable. While 0, no new word is accepted. A word already in flight still drains.
- `d` input 4: multi-hot input word.
- `in_valid` input 1: `d` is valid this cycle.
- `in_ready` output 1: combinational, equals `e & (state==IDLE) & ~rst`.
- `a` output 2: registered code (index of the current set bit).
- `out_valid` output 1: registered; `a`, `last` and `count` are valid.
- `out_ready` input 1: downstream accepts the current code.
- `last` output 1: registered; current code is the final one of its word.
- `count` output 3: registered popcount of the captured word (0–4), held for the whole word.
- `empty` output 1: registered one-cycle pulse when an all-zero word is accepted.

## Operation
- States: IDLE, BUSY.
- **Accept.** An accept occurs when `in_valid & in_ready` is high at a clock edge.
- **Accept of a non-zero word in IDLE:**
  - `pend <= d`; `count <= popcount(d)`.
  - `a <=` index of the highest set bit of `d`.
  - `last <=` (popcount==1); `out_valid <= 1`; go to BUSY.
- **Accept of `d==4'b0000`:**
  - `empty <= 1` for one cycle; stay in IDLE.
  - No code is emitted; `count <= 0`.
- **In BUSY, on `out_valid & out_ready`:**
  - Clear bit `a` in `pend`.
  - If `last` was 1: `out_valid <= 0`, `last <= 0`, go to IDLE.
  - Otherwise: `a <=` next-highest remaining bit; `last <=` (one bit left after the clear).
- **Stall.** In BUSY with `out_ready==0`, `a`, `last`, `count` and `out_valid` hold unchanged. This is the stall rule; the output must never change while `out_valid & ~out_ready`.
- **Priority.** Emission order is strictly bit 3, 2, 1, 0 among the set bits. Index encoding: bit k gives `a = k` (bit3→2'b11, bit0→2'b00).
- **Enable.** `e` is ignored in BUSY, so deasserting it mid-word does not abort the word.
- **Overlap.** In IDLE, `in_valid` with `in_ready==0` (because `e==0`) is dropped, not queued. No overlap: a new word is never accepted in the cycle the last code is consumed. `in_ready` rises the cycle after.

## Timing
- **Reset values** (cycle after `rst` sampled high):
  - `a=2'b00`, `out_valid=0`, `last=0`, `count=3'd0`, `empty=0`.
  - `pend=4'b0000`; state IDLE.
  - `in_ready=0` while `rst=1`.
- **Reset mid-word.** Reset in BUSY discards the remaining bits; no further codes are emitted.
- **Latency.** Accept at edge N gives the first code with `out_valid=1` after edge N, i.e. visible in cycle N+1.
- **Throughput.** One code per cycle with `out_ready` held high. A word with k set bits occupies k cycles of BUSY plus one IDLE cycle before the next accept, for a minimum accept spacing of k+1 cycles.
- **`empty` timing.** `empty` is high for exactly the cycle after the zero-word accept. `in_ready` stays high, so back-to-back zero words pulse `empty` on consecutive cycles.

## Test plan
- **Reset.** Drive `rst=1` for 2 cycles with `in_valid=1`, `d=4'b1111`, `e=1` → `in_ready=0`, `out_valid=0`, `a=0`, `count=0`, `empty=0`; nothing is captured.
- **Full word, no stall.** `e=1`, `d=4'b1011` accepted with `out_ready=1` → codes 2'b11, 2'b01, 2'b00 on 3 consecutive cycles with `last=0,0,1` and `count=3` throughout. `in_ready` returns to 1 one cycle after the last code.
- **Stall.** Accept `d=4'b0110` with `out_ready=0` for 3 cycles → `a=2'b10`, `out_valid=1`, `last=0` held stable. Raise `out_ready` → next code 2'b01 with `last=1`, then `out_valid=0`.
- **Zero word and enable.**
  - `d=4'b0000` accepted → `empty` pulses for 1 cycle and no `out_valid`.
  - `e=0` with `in_valid=1`, `d=4'b0001` → `in_ready=0`, no output.
- **Enable drop and reset mid-word.**
  - Accept `d=4'b1111`, drop `e` after the first code → all 4 codes 3, 2, 1, 0 are still emitted.
  - Repeat, but assert `rst` after the second code → `out_valid=0` next cycle and no further codes.
- **Exhaustive round trip.** Loop all 16 values of `d` through `e42_ser` into `d24` with `e=1` → the OR of the decoded one-hots equals `d`. `count` matches popcount for every value.
